// File: rtl/picoblaze_interrupt_controller.sv
// Four-source interrupt controller on a PicoBlaze port window (status, mask, data/EOI, overrun).
// Define INT_ROUND_ROBIN_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module picoblaze_interrupt_controller #(
  parameter logic [7:0]  PORT_BASE          = 8'h10,
  parameter int unsigned ACK_TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  irq_event,
  input  logic [31:0] irq_data,
  output logic        interrupt,
  input  logic        interrupt_ack,
  input  logic [7:0]  port_id,
  input  logic        read_strobe,
  input  logic        write_strobe,
  input  logic [7:0]  out_port,
  output logic [7:0]  in_port,
  output logic [3:0]  overrun
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  localparam logic [7:0]  ADDR_STATUS  = {PORT_BASE[7:2], 2'd0};
  localparam logic [7:0]  ADDR_MASK    = {PORT_BASE[7:2], 2'd1};
  localparam logic [7:0]  ADDR_EOI     = {PORT_BASE[7:2], 2'd2};
  localparam logic [7:0]  ADDR_OVR     = {PORT_BASE[7:2], 2'd3};
  localparam logic [15:0] TIMEOUT_LAST = 16'(ACK_TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic [3:0]  pending, mask, overrun_flags, irq_prev;
  logic        hist_valid;
  logic [7:0]  data [4];
  logic [1:0]  grant_id, grant_sel;
  logic        timeout;
  logic [15:0] ack_count;
  logic [3:0]  eligible, rise, eoi_clear, ovr_set, ovr_clear;
  logic        grant_load, eoi, timeout_hit, status_read;
  logic [7:0]  read_value;
  logic        unused_out_bits;

  assign unused_out_bits = ^out_port[7:4];
  assign overrun         = overrun_flags;
  assign eligible        = pending & mask;
  // History is invalid for one cycle after reset so a level already high is not an edge.
  assign rise            = hist_valid ? (irq_event & ~irq_prev) : 4'b0000;
  assign eoi_clear       = eoi ? (4'b0001 << grant_id) : 4'b0000;
  assign ovr_set         = rise & pending & ~eoi_clear;
  assign ovr_clear       = (write_strobe && port_id == ADDR_OVR) ? out_port[3:0] : 4'b0000;
  assign status_read     = read_strobe && port_id == ADDR_STATUS;

`ifdef INT_ROUND_ROBIN_EN
  logic [1:0] rr_ptr, rr_idx;

  always_comb begin
    grant_sel = rr_ptr;
    rr_idx    = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      rr_idx = rr_ptr + 2'(k);
      if (eligible[rr_idx]) grant_sel = rr_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rr_ptr <= 2'd0;
    else if (grant_load) rr_ptr <= grant_sel + 2'd1;
  end
`else
  always_comb begin
    grant_sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (eligible[i]) grant_sel = 2'(i);
    end
  end
`endif

  always_comb begin
    state_next  = state;
    grant_load  = 1'b0;
    eoi         = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (|eligible) begin
          state_next = REQ;
          grant_load = 1'b1;
        end
      end
      REQ: begin
        if (interrupt_ack) begin
          state_next = SERVICE;
        end else if (ack_count == TIMEOUT_LAST) begin
          state_next  = IDLE;
          timeout_hit = 1'b1;
        end
      end
      SERVICE: begin
        if (write_strobe && port_id == ADDR_EOI) begin
          state_next = IDLE;
          eoi        = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    read_value = 8'h00;
    case (port_id)
      ADDR_STATUS: read_value = {timeout, 3'b000, state != IDLE, 1'b0, grant_id};
      ADDR_MASK:   read_value = {4'h0, mask};
      ADDR_EOI:    read_value = data[grant_id];
      ADDR_OVR:    read_value = {4'h0, overrun_flags};
      default:     read_value = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      interrupt     <= 1'b0;
      in_port       <= 8'h00;
      pending       <= 4'h0;
      overrun_flags <= 4'h0;
      mask          <= 4'hF;
      grant_id      <= 2'd0;
      timeout       <= 1'b0;
      ack_count     <= 16'd0;
      irq_prev      <= 4'h0;
      hist_valid    <= 1'b0;
      for (int i = 0; i < 4; i++) data[i] <= 8'h00;
    end else begin
      state         <= state_next;
      interrupt     <= (state_next == REQ);
      in_port       <= read_value;
      irq_prev      <= irq_event;
      hist_valid    <= 1'b1;
      pending       <= (pending & ~eoi_clear) | rise;
      overrun_flags <= (overrun_flags & ~ovr_clear) | ovr_set;
      ack_count     <= (state == REQ) ? ack_count + 16'd1 : 16'd0;
      if (grant_load) grant_id <= grant_sel;
      if (write_strobe && port_id == ADDR_MASK) mask <= out_port[3:0];
      if (timeout_hit) timeout <= 1'b1;
      else if (status_read) timeout <= 1'b0;
      // A new edge replaces the byte only when the slot is free or being retired this cycle.
      for (int i = 0; i < 4; i++) begin
        if (rise[i] && (!pending[i] || eoi_clear[i])) data[i] <= irq_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_picoblaze_interrupt_controller.sv
// Directed self-checking bench for picoblaze_interrupt_controller (fixed-priority build, ack timeout of 4).
module tb_picoblaze_interrupt_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq_event;
  logic [31:0] irq_data;
  logic        interrupt;
  logic        interrupt_ack;
  logic [7:0]  port_id;
  logic        read_strobe;
  logic        write_strobe;
  logic [7:0]  out_port;
  logic [7:0]  in_port;
  logic [3:0]  overrun;

  int total = 0;
  int bad   = 0;
  logic [7:0] rd;

  picoblaze_interrupt_controller #(
    .PORT_BASE(8'h10),
    .ACK_TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .irq_event(irq_event),
    .irq_data(irq_data),
    .interrupt(interrupt),
    .interrupt_ack(interrupt_ack),
    .port_id(port_id),
    .read_strobe(read_strobe),
    .write_strobe(write_strobe),
    .out_port(out_port),
    .in_port(in_port),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] ev, input logic [31:0] dat);
    irq_event = ev;
    irq_data  = dat;
    tick();
  endtask

  task automatic ackOnce();
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
  endtask

  task automatic writePort(input logic [7:0] addr, input logic [7:0] value);
    port_id      = addr;
    out_port     = value;
    write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
    out_port     = 8'h00;
  endtask

  task automatic readPort(input logic [7:0] addr, output logic [7:0] value);
    port_id     = addr;
    read_strobe = 1'b1;
    tick();
    read_strobe = 1'b0;
    value       = in_port;
  endtask

  initial begin
    reset = 1'b1; irq_event = 4'h0; irq_data = 32'h0; interrupt_ack = 1'b0;
    port_id = 8'h00; read_strobe = 1'b0; write_strobe = 1'b0; out_port = 8'h00;
    tick(); tick();
    checkOutput("reset_interrupt", {7'd0, interrupt}, 8'h00);
    checkOutput("reset_in_port", in_port, 8'h00);
    checkOutput("reset_overrun", {4'd0, overrun}, 8'h00);
    reset = 1'b0;
    tick();
    readPort(8'h11, rd); checkOutput("reset_mask", rd, 8'h0F);
    readPort(8'h10, rd); checkOutput("reset_status", rd, 8'h00);

    $display("[TB] single request on source 2");
    applyStimulus(4'b0100, 32'h005A_0000);
    checkOutput("single_irq_early", {7'd0, interrupt}, 8'h00);
    applyStimulus(4'b0000, 32'h0);
    checkOutput("single_irq_up", {7'd0, interrupt}, 8'h01);
    ackOnce();
    checkOutput("single_irq_ack", {7'd0, interrupt}, 8'h00);
    readPort(8'h10, rd); checkOutput("single_status", rd, 8'h0A);
    readPort(8'h12, rd); checkOutput("single_data", rd, 8'h5A);
    writePort(8'h12, 8'hFF);
    readPort(8'h10, rd); checkOutput("single_status_eoi", rd, 8'h02);
    checkOutput("single_irq_idle", {7'd0, interrupt}, 8'h00);
    readPort(8'h20, rd); checkOutput("unmapped_read", rd, 8'h00);

    $display("[TB] simultaneous sources 0 and 3");
    applyStimulus(4'b1001, 32'hC300_003C);
    applyStimulus(4'b0000, 32'h0);
    checkOutput("pair_irq_first", {7'd0, interrupt}, 8'h01);
    ackOnce();
    readPort(8'h10, rd); checkOutput("pair_status_first", rd, 8'h08);
    readPort(8'h12, rd); checkOutput("pair_data_first", rd, 8'h3C);
    writePort(8'h12, 8'h00);
    tick();
    checkOutput("pair_irq_second", {7'd0, interrupt}, 8'h01);
    ackOnce();
    readPort(8'h10, rd); checkOutput("pair_status_second", rd, 8'h0B);
    readPort(8'h12, rd); checkOutput("pair_data_second", rd, 8'hC3);
    writePort(8'h12, 8'h00);
    applyStimulus(4'b1001, 32'h1100_0022);
    applyStimulus(4'b0000, 32'h0);
    ackOnce();
    readPort(8'h10, rd); checkOutput("pair2_status_first", rd, 8'h08);
    readPort(8'h12, rd); checkOutput("pair2_data_first", rd, 8'h22);
    writePort(8'h12, 8'h00);
    tick();
    ackOnce();
    readPort(8'h10, rd); checkOutput("pair2_status_second", rd, 8'h0B);
    writePort(8'h12, 8'h00);

    $display("[TB] overrun on source 1");
    applyStimulus(4'b0010, 32'h0000_7700);
    applyStimulus(4'b0000, 32'h0);
    interrupt_ack = 1'b1;
    applyStimulus(4'b0010, 32'h0000_8800);
    interrupt_ack = 1'b0;
    checkOutput("ovr_flag", {4'd0, overrun}, 8'h02);
    readPort(8'h13, rd); checkOutput("ovr_reg", rd, 8'h02);
    readPort(8'h12, rd); checkOutput("ovr_data_kept", rd, 8'h77);
    writePort(8'h13, 8'h02);
    checkOutput("ovr_cleared", {4'd0, overrun}, 8'h00);
    writePort(8'h12, 8'h00);
    applyStimulus(4'b0000, 32'h0);

    $display("[TB] masking source 0");
    writePort(8'h11, 8'h0E);
    applyStimulus(4'b0001, 32'h0000_00A5);
    applyStimulus(4'b0000, 32'h0);
    tick(); tick();
    checkOutput("mask_blocks", {7'd0, interrupt}, 8'h00);
    readPort(8'h11, rd); checkOutput("mask_reg", rd, 8'h0E);
    writePort(8'h11, 8'h0F);
    tick();
    checkOutput("mask_release", {7'd0, interrupt}, 8'h01);
    ackOnce();
    readPort(8'h10, rd); checkOutput("mask_status", rd, 8'h08);
    writePort(8'h12, 8'h00);

    $display("[TB] acknowledge timeout");
    applyStimulus(4'b0100, 32'h0033_0000);
    applyStimulus(4'b0000, 32'h0);
    checkOutput("to_high_0", {7'd0, interrupt}, 8'h01);
    for (int n = 1; n < 4; n++) begin
      tick();
      checkOutput($sformatf("to_high_%0d", n), {7'd0, interrupt}, 8'h01);
    end
    tick();
    checkOutput("to_drop", {7'd0, interrupt}, 8'h00);
    readPort(8'h10, rd); checkOutput("to_status_set", rd, 8'h82);
    checkOutput("to_reassert", {7'd0, interrupt}, 8'h01);
    readPort(8'h10, rd); checkOutput("to_status_clr", rd, 8'h0A);
    ackOnce();
    writePort(8'h12, 8'h00);

    $display("[TB] reset while in service");
    applyStimulus(4'b1000, 32'hEE00_0000);
    tick();
    ackOnce();
    applyStimulus(4'b0000, 32'h0);
    applyStimulus(4'b1000, 32'h9900_0000);
    checkOutput("rst_ovr_before", {4'd0, overrun}, 8'h08);
    readPort(8'h12, rd); checkOutput("rst_data_before", rd, 8'hEE);
    reset = 1'b1;
    tick();
    checkOutput("rst_interrupt", {7'd0, interrupt}, 8'h00);
    checkOutput("rst_in_port", in_port, 8'h00);
    checkOutput("rst_overrun", {4'd0, overrun}, 8'h00);
    reset = 1'b0;
    tick(); tick(); tick();
    checkOutput("rst_held_no_irq", {7'd0, interrupt}, 8'h00);
    readPort(8'h10, rd); checkOutput("rst_status", rd, 8'h00);
    applyStimulus(4'b0000, 32'h0);
    applyStimulus(4'b1000, 32'h1200_0000);
    tick();
    checkOutput("rst_toggle_irq", {7'd0, interrupt}, 8'h01);
    ackOnce();
    readPort(8'h12, rd); checkOutput("rst_toggle_data", rd, 8'h12);
    writePort(8'h12, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
